// File: rtl/usb_upload_framer_if.sv
// rtl/usb_upload_framer_if.sv - request, payload and upload-stream signals of the USB upload framer
interface usb_upload_framer_if;
    logic        start;
    logic        start_ready;
    logic [7:0]  cmd;
    logic [15:0] len;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  usb_upload_data;
    logic        usb_upload_valid;
    logic        usb_upload_ready;
    logic        busy;
    logic        err_len;
    logic        err_underrun;

    modport slave (
        input  start, cmd, len, pl_data, pl_valid, usb_upload_ready,
        output start_ready, pl_ready, usb_upload_data, usb_upload_valid,
               busy, err_len, err_underrun
    );

    modport master (
        output start, cmd, len, pl_data, pl_valid, usb_upload_ready,
        input  start_ready, pl_ready, usb_upload_data, usb_upload_valid,
               busy, err_len, err_underrun
    );
endinterface

// File: rtl/usb_upload_framer.sv
// rtl/usb_upload_framer.sv - frames AA 44 cmd len payload checksum onto the USB upload byte stream
module usb_upload_framer #(
    parameter logic [7:0]  HDR0    = 8'hAA,
    parameter logic [7:0]  HDR1    = 8'h44,
    parameter logic [15:0] MAX_LEN = 16'd4096,
    parameter logic [19:0] TIMEOUT = 20'd60000
) (
    input logic                 clk,
    input logic                 rst,
    usb_upload_framer_if.slave  frm_io
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_H0   = 3'd1;
    localparam logic [2:0] S_H1   = 3'd2;
    localparam logic [2:0] S_CMD  = 3'd3;
    localparam logic [2:0] S_LENH = 3'd4;
    localparam logic [2:0] S_LENL = 3'd5;
    localparam logic [2:0] S_PAY  = 3'd6;
    localparam logic [2:0] S_CSUM = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  csum_q, csum_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic        padding_q, padding_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_len_q, err_len_d;
    logic        err_underrun_q, err_underrun_d;

    logic        out_free;
    logic        load;
    logic [7:0]  load_byte;
    logic [19:0] to_cnt_inc;

    assign out_free   = !valid_q || frm_io.usb_upload_ready;
    assign to_cnt_inc = to_cnt_q + 20'd1;

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        len_d          = len_q;
        rem_d          = rem_q;
        csum_d         = csum_q;
        to_cnt_d       = to_cnt_q;
        padding_d      = padding_q;
        err_len_d      = 1'b0;
        err_underrun_d = 1'b0;
        load           = 1'b0;
        load_byte      = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (frm_io.start) begin
                    if (frm_io.len > MAX_LEN) begin
                        err_len_d = 1'b1;
                    end else begin
                        cmd_d    = frm_io.cmd;
                        len_d    = frm_io.len;
                        rem_d    = frm_io.len;
                        csum_d   = 8'h00;
                        to_cnt_d = 20'd0;
                        // Loading HDR0 straight away lets a frame follow the previous checksum with no gap
                        if (out_free) begin
                            load      = 1'b1;
                            load_byte = HDR0;
                            state_d   = S_H1;
                        end else begin
                            state_d   = S_H0;
                        end
                    end
                end
            end
            S_H0: if (out_free) begin
                load = 1'b1; load_byte = HDR0; state_d = S_H1;
            end
            S_H1: if (out_free) begin
                load = 1'b1; load_byte = HDR1; state_d = S_CMD;
            end
            S_CMD: if (out_free) begin
                load = 1'b1; load_byte = cmd_q; csum_d = csum_q + cmd_q; state_d = S_LENH;
            end
            S_LENH: if (out_free) begin
                load = 1'b1; load_byte = len_q[15:8]; csum_d = csum_q + len_q[15:8]; state_d = S_LENL;
            end
            S_LENL: if (out_free) begin
                load      = 1'b1;
                load_byte = len_q[7:0];
                csum_d    = csum_q + len_q[7:0];
                state_d   = (len_q == 16'd0) ? S_CSUM : S_PAY;
            end
            S_PAY: if (out_free) begin
                if (padding_q || frm_io.pl_valid) begin
                    load      = 1'b1;
                    load_byte = padding_q ? 8'h00 : frm_io.pl_data;
                    csum_d    = csum_q + load_byte;
                    rem_d     = rem_q - 16'd1;
                    to_cnt_d  = 20'd0;
                    if (rem_q == 16'd1) state_d = S_CSUM;
                end else if (to_cnt_inc == TIMEOUT) begin
                    err_underrun_d = 1'b1;
                    padding_d      = 1'b1;
                    to_cnt_d       = 20'd0;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            S_CSUM: if (out_free) begin
                load = 1'b1; load_byte = csum_q; padding_d = 1'b0; state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        data_d  = load ? load_byte : data_q;
        valid_d = load ? 1'b1 : (out_free ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cmd_q          <= 8'h00;
            len_q          <= 16'd0;
            rem_q          <= 16'd0;
            csum_q         <= 8'h00;
            to_cnt_q       <= 20'd0;
            padding_q      <= 1'b0;
            data_q         <= 8'h00;
            valid_q        <= 1'b0;
            err_len_q      <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            len_q          <= len_d;
            rem_q          <= rem_d;
            csum_q         <= csum_d;
            to_cnt_q       <= to_cnt_d;
            padding_q      <= padding_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            err_len_q      <= err_len_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign frm_io.start_ready      = (state_q == S_IDLE);
    assign frm_io.busy             = (state_q != S_IDLE);
    assign frm_io.pl_ready         = (state_q == S_PAY) && out_free && !padding_q;
    assign frm_io.usb_upload_data  = data_q;
    assign frm_io.usb_upload_valid = valid_q;
    assign frm_io.err_len          = err_len_q;
    assign frm_io.err_underrun     = err_underrun_q;
endmodule

// File: tb/tb_usb_upload_framer.sv
// tb/tb_usb_upload_framer.sv - randomized self-checking bench for usb_upload_framer against a frame-level model
module tb_usb_upload_framer;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_upload_framer_if f();

    usb_upload_framer #(.TIMEOUT(20'd8)) dut (
        .clk    (clk),
        .rst    (rst),
        .frm_io (f.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] pay [0:4095];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int stall_bad, nur, nplr, busy_bad, nelen, first_v, last_hs, ur_cyc, last_take;
    logic sr_end;

    // Whole-frame reference: header, cmd, length, payload (zeros beyond the first n_sup bytes), mod-256 sum
    task automatic build_exp(input logic [7:0] c, input logic [15:0] l, input int n_sup);
        int sum;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h44);
        exp_q.push_back(c);
        exp_q.push_back(l[15:8]);
        exp_q.push_back(l[7:0]);
        sum = int'(c) + int'(l[15:8]) + int'(l[7:0]);
        for (int i = 0; i < int'(l); i++) begin
            b = (i < n_sup) ? pay[i] : 8'h00;
            exp_q.push_back(b);
            sum = sum + int'(b);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_frame(input logic [7:0] c, input logic [15:0] l, input int n_sup,
                               input int rmode, input int gap_pct);
        int pidx, idle_run, total, cyc;
        logic prev_stall, took;
        logic [7:0] prev_data;
        pidx = 0; idle_run = 0; total = int'(l) + 6;
        prev_stall = 1'b0; prev_data = 8'h00;
        got_q.delete();
        stall_bad = 0; nur = 0; nplr = 0; busy_bad = 0; nelen = 0;
        first_v = -1; last_hs = -1; ur_cyc = -1; last_take = -1; sr_end = 1'b0;
        f.start = 1'b1; f.cmd = c; f.len = l;
        f.pl_valid = 1'b0; f.pl_data = 8'h00; f.usb_upload_ready = 1'b1;
        for (cyc = 0; cyc < 20000 && got_q.size() < total; cyc++) begin
            @(negedge clk);
            if (cyc >= 1 && int'(got_q.size()) + int'(f.usb_upload_valid) < total && !f.busy)
                busy_bad++;
            if (f.err_underrun) begin nur++; ur_cyc = cyc; end
            if (f.pl_ready) nplr++;
            if (f.err_len) nelen++;
            if (prev_stall && !(f.usb_upload_valid === 1'b1 && f.usb_upload_data === prev_data))
                stall_bad++;
            prev_stall = f.usb_upload_valid && !f.usb_upload_ready;
            prev_data  = f.usb_upload_data;
            if (f.usb_upload_valid && first_v < 0) first_v = cyc;
            took = f.pl_valid && f.pl_ready;
            if (took) last_take = cyc;
            if (f.usb_upload_valid && f.usb_upload_ready) begin
                got_q.push_back(f.usb_upload_data);
                last_hs = cyc;
                if (got_q.size() == total) sr_end = f.start_ready;
            end
            step();
            f.start = 1'b0;
            if (took) pidx++;
            if (pidx < n_sup && (idle_run >= 3 || $urandom_range(99) >= gap_pct)) begin
                f.pl_valid = 1'b1; f.pl_data = pay[pidx]; idle_run = 0;
            end else begin
                f.pl_valid = 1'b0; f.pl_data = 8'($urandom); idle_run++;
            end
            case (rmode)
                0: f.usb_upload_ready = 1'b1;
                1: f.usb_upload_ready = ~f.usb_upload_ready;
                default: f.usb_upload_ready = 1'($urandom_range(1));
            endcase
        end
        f.pl_valid = 1'b0;
        f.usb_upload_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (f.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", f.start_ready); end
        checks++; if (f.usb_upload_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", f.usb_upload_valid); end
        checks++; if (f.usb_upload_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", f.usb_upload_data); end
        checks++; if (f.pl_ready !== 1'b0) begin errors++; $display("FAIL reset_pl_ready: got %b want 0", f.pl_ready); end
        checks++; if (f.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", f.busy); end
        checks++; if ({f.err_len, f.err_underrun} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {f.err_len, f.err_underrun}); end
        step();
    endtask

    task automatic check_seq(input string name);
        int d;
        d = first_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL %s: bytes differ at index %0d (got %h, want %h), got %0d bytes want %0d",
                     name, d, got_q[d], exp_q[d], got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_single();
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        drive_frame(8'h10, 16'd3, 3, 0, 0);
        build_exp(8'h10, 16'd3, 3);
        check_seq("single_bytes");
        checks++; if (exp_q[8] !== 8'h19) begin errors++; $display("FAIL single_csum_model: got %h want 19", exp_q[8]); end
        checks++; if (first_v !== 1 || last_hs - first_v !== 8) begin errors++; $display("FAIL single_timing: first %0d span %0d want 1 and 8", first_v, last_hs - first_v); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL single_busy: got %0d low cycles want 0", busy_bad); end
        checks++; if (sr_end !== 1'b1) begin errors++; $display("FAIL single_start_ready: got %b want 1", sr_end); end
    endtask

    task automatic test_zero_len();
        drive_frame(8'h05, 16'd0, 0, 0, 0);
        build_exp(8'h05, 16'd0, 0);
        check_seq("zero_bytes");
        checks++; if (nplr !== 0) begin errors++; $display("FAIL zero_pl_ready: got %0d cycles want 0", nplr); end
    endtask

    task automatic test_backpressure();
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        drive_frame(8'h10, 16'd3, 3, 1, 0);
        build_exp(8'h10, 16'd3, 3);
        check_seq("bp_bytes");
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
    endtask

    task automatic test_len_reject();
        f.start = 1'b1; f.cmd = 8'h77; f.len = 16'd4097;
        step();
        f.start = 1'b0;
        @(negedge clk);
        checks++; if (f.err_len !== 1'b1) begin errors++; $display("FAIL rej_err_len: got %b want 1", f.err_len); end
        checks++; if (f.usb_upload_valid !== 1'b0) begin errors++; $display("FAIL rej_valid: got %b want 0", f.usb_upload_valid); end
        checks++; if (f.start_ready !== 1'b1) begin errors++; $display("FAIL rej_start_ready: got %b want 1", f.start_ready); end
        step();
        @(negedge clk);
        checks++; if (f.err_len !== 1'b0 || f.usb_upload_valid !== 1'b0) begin errors++; $display("FAIL rej_pulse_width: err_len %b valid %b want 0 0", f.err_len, f.usb_upload_valid); end
        step();
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 4096; i++) pay[i] = 8'($urandom);
        drive_frame(8'h42, 16'd4096, 4096, 0, 20);
        build_exp(8'h42, 16'd4096, 4096);
        check_seq("maxlen_bytes");
        checks++; if (nelen !== 0 || nur !== 0) begin errors++; $display("FAIL maxlen_errs: err_len %0d underrun %0d want 0 0", nelen, nur); end
    endtask

    task automatic test_underrun();
        pay[0] = 8'h7F;
        drive_frame(8'h20, 16'd4, 1, 0, 0);
        build_exp(8'h20, 16'd4, 1);
        check_seq("underrun_bytes");
        checks++; if (exp_q[9] !== 8'hA3) begin errors++; $display("FAIL underrun_csum_model: got %h want a3", exp_q[9]); end
        checks++; if (nur !== 1) begin errors++; $display("FAIL underrun_pulses: got %0d want 1", nur); end
        checks++; if (ur_cyc - last_take !== TMO + 1) begin errors++; $display("FAIL underrun_delay: got %0d want %0d", ur_cyc - last_take, TMO + 1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$];
        int fv, nv;
        logic drop;
        pay[0] = 8'h0F;
        build_exp(8'h31, 16'd1, 1);
        qa = exp_q;
        build_exp(8'h05, 16'd0, 0);
        for (int i = qa.size() - 1; i >= 0; i--) exp_q.push_front(qa[i]);
        got_q.delete();
        fv = -1; nv = 0; drop = 1'b0;
        f.start = 1'b1; f.cmd = 8'h31; f.len = 16'd1;
        f.pl_valid = 1'b1; f.pl_data = 8'h0F; f.usb_upload_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (f.usb_upload_valid) begin
                if (fv < 0) fv = cyc;
                if (cyc - fv == nv) nv++;
            end
            if (f.usb_upload_valid && f.usb_upload_ready) got_q.push_back(f.usb_upload_data);
            if (cyc > 0 && f.start_ready && f.start) drop = 1'b1;
            step();
            if (cyc == 0) begin f.cmd = 8'h05; f.len = 16'd0; end
            if (drop) f.start = 1'b0;
        end
        f.start = 1'b0; f.pl_valid = 1'b0;
        check_seq("b2b_bytes");
        checks++; if (nv !== 13) begin errors++; $display("FAIL b2b_no_gap: got %0d contiguous bytes want 13", nv); end
    endtask

    task automatic test_reset_mid();
        int taken;
        taken = 0;
        for (int i = 0; i < 5; i++) pay[i] = 8'(i + 8'h50);
        f.start = 1'b1; f.cmd = 8'h66; f.len = 16'd5;
        f.pl_valid = 1'b0; f.usb_upload_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && taken < 2; cyc++) begin
            @(negedge clk);
            if (f.pl_valid && f.pl_ready) taken++;
            step();
            f.start = 1'b0;
            f.pl_valid = 1'b1; f.pl_data = pay[taken];
        end
        checks++; if (taken < 2) begin errors++; $display("FAIL rstmid_reach_payload: got %0d bytes want 2", taken); end
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++; if (f.usb_upload_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", f.usb_upload_valid); end
        checks++; if (f.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", f.busy); end
        checks++; if (f.start_ready !== 1'b1 || f.pl_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: start_ready %b pl_ready %b want 1 0", f.start_ready, f.pl_ready); end
        step();
        rst = 1'b0; f.pl_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [7:0] c;
        logic [15:0] l;
        for (int n = 0; n < 8; n++) begin
            c = 8'($urandom);
            l = 16'($urandom_range(0, 24));
            for (int i = 0; i < int'(l); i++) pay[i] = 8'($urandom);
            drive_frame(c, l, int'(l), 2, 30);
            build_exp(c, l, int'(l));
            check_seq("random_bytes");
            checks++; if (stall_bad !== 0 || nur !== 0) begin errors++; $display("FAIL random_flow: unstable %0d underruns %0d want 0 0", stall_bad, nur); end
        end
    endtask

    initial begin
        f.start = 1'b0; f.cmd = 8'h00; f.len = 16'd0;
        f.pl_data = 8'h00; f.pl_valid = 1'b0; f.usb_upload_ready = 1'b1;
        test_reset();
        test_single();
        test_zero_len();
        test_backpressure();
        test_len_reject();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/usb_upload_framer.md
Name: usb_upload_framer

Overview:
- Transmit-side framer for the USB CDC command link, running in the PHY_CLK (60 MHz) domain.
- Builds response frames from a command code, a payload length and a payload byte stream, and serialises them as a byte stream on the USB upload interface.
- The frame format is: header 0xAA 0x44, command, length high byte, length low byte, payload, checksum.
- Sits between the function modules (capture, DSM, I2C, SPI readback) and the USB CDC upload port.

Parameters:
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h44, second header byte.
- MAX_LEN, 16'd4096, largest payload length accepted.
- TIMEOUT, 20'd60000, payload-stall limit in clk cycles before zero-padding.

Ports:
- clk  in  1  PHY_CLK domain clock.
- rst  in  1  Synchronous reset, active-high.
- start  in  1  Frame request. Sampled only when start_ready=1.
- start_ready  out  1  High in IDLE: the framer can accept a request.
- cmd  in  8  Command code, captured on start.
- len  in  16  Payload byte count, captured on start.
- pl_data  in  8  Payload byte.
- pl_valid  in  1  Payload byte valid.
- pl_ready  out  1  Payload byte accepted when pl_valid & pl_ready.
- usb_upload_data  out  8  Framed output byte.
- usb_upload_valid  out  1  Output byte valid. Held until usb_upload_ready.
- usb_upload_ready  in  1  Downstream accepts the byte. Tie to 1 if there is no backpressure.
- busy  out  1  Frame in progress (not IDLE).
- err_len  out  1  One-cycle pulse: a start was rejected because len > MAX_LEN.
- err_underrun  out  1  One-cycle pulse: payload timeout fired and padding began.

Behaviour:
- Reset:
  - state=IDLE; start_ready=1 in the cycle after reset deasserts.
  - usb_upload_valid=0, usb_upload_data=0, pl_ready=0, busy=0, err_len=0, err_underrun=0.
  - Checksum, byte counter and timeout counter are all cleared.
- Output register:
  - Single stage. It loads a new byte when (!usb_upload_valid || usb_upload_ready).
  - usb_upload_data is stable while usb_upload_valid=1 and usb_upload_ready=0.
- States: IDLE -> H0 -> H1 -> CMD -> LENH -> LENL -> PAY -> CSUM -> IDLE. Each emitting state loads exactly one byte into the output register, then advances.
- IDLE:
  - On start with len <= MAX_LEN: capture cmd and len, clear checksum, go to H0.
  - On start with len > MAX_LEN: pulse err_len, stay in IDLE, emit nothing.
- Header bytes: H0 emits HDR0 and H1 emits HDR1. Header bytes are excluded from the checksum.
- CMD, LENH and LENL emit cmd, len[15:8] and len[7:0]. Each of these bytes is added to the checksum.
- LENL goes to CSUM directly when len=0; otherwise to PAY.
- Checksum is an 8-bit modulo-256 sum of cmd, len_hi, len_lo and all payload bytes (padding included).
- PAY:
  - pl_ready = (state==PAY) && (!usb_upload_valid || usb_upload_ready) && !padding.
  - Each handshake loads pl_data, adds it to the checksum and decrements the remaining count.
  - Going to CSUM happens on the handshake of the last byte.
  - pl_ready is 0 in every other state.
- Timeout and padding:
  - In PAY, the timeout counter increments on each cycle where the output register is free and pl_valid=0. It clears on each payload handshake.
  - When the counter reaches TIMEOUT: pulse err_underrun and set padding.
  - While padding, 0x00 bytes are emitted at output pace (counted and summed) until the remaining count is 0, then CSUM.
  - Padding clears on entry to IDLE.
- CSUM: emits the checksum byte, then goes to IDLE.
- start_ready rises in the cycle after the checksum byte loads. The checksum byte may still be pending on the output.
- A new frame's HDR0 loads only once the output register is free. This gives back-to-back frames with no gap when usb_upload_ready=1.
- Throughput: with usb_upload_ready=1 and pl_valid=1, one byte per clk. Start to first usb_upload_valid is 1 cycle.
- start while busy is ignored (start_ready=0). cmd and len changes during a frame have no effect.
- Reset mid-frame: everything returns to reset values on the next edge and the partial frame is abandoned.

Test Plan:
- Single frame: cmd=0x10, len=3, payload 01 02 03, usb_upload_ready=1 -> bytes AA 44 10 00 03 01 02 03 19 on consecutive cycles; busy high throughout; start_ready back high after byte 0x19.
- Zero length: cmd=0x05, len=0 -> AA 44 05 00 00 05; pl_ready never asserts.
- Backpressure: same as the first test with usb_upload_ready toggling 1/0 every cycle -> identical byte sequence; data stable while stalled; no payload byte lost or duplicated.
- Length reject: len=4097 -> err_len pulses for 1 cycle; usb_upload_valid stays 0; start_ready stays 1.
- Underrun: TIMEOUT=8, cmd=0x20, len=4, only byte 0x7F supplied, then pl_valid=0 -> err_underrun after 8 idle cycles; output AA 44 20 00 04 7F 00 00 00 A3.
- Back-to-back and reset: a second start in the cycle start_ready rises -> its AA follows the prior checksum with no gap. Assert rst during a payload byte -> next cycle has usb_upload_valid=0, busy=0, start_ready=1.
